// File: rtl/reg_file_sb.sv
// Integer register file: NRD combinational read ports, one write port, x0 tied to zero,
// per-register busy scoreboard and a one-entry-per-cycle clear sequencer.
// Define RF_BYPASS_EN to forward same-cycle write data/busy onto matching read ports.
//
// state    | meaning
// ST_CLEAR | sequencer zeroing ram[cnt], cnt = 1..NREG-1; reads return 0, writes/reservations dropped
// ST_READY | normal operation; RF_ready = 1
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RF_adr,
    output logic [NRD*XLEN-1:0] RF_rd,
    output logic [NRD-1:0]      RF_busy,
    input  logic                RF_en,
    input  logic [AW-1:0]       RF_wa,
    input  logic [XLEN-1:0]     RF_wd,
    input  logic                RF_rsv_en,
    input  logic [AW-1:0]       RF_rsv_adr,
    input  logic                RF_clr,
    output logic                RF_ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] ram_q [NREG];

    logic            is_ready;
    logic            wr_fire;
    logic            rsv_fire;
    logic            ram_we;
    logic [AW-1:0]   ram_wa;
    logic [XLEN-1:0] ram_wdata;

    assign is_ready = (state_q == ST_READY);
    assign RF_ready = is_ready;

    // A soft-clear request takes priority over any write or reservation on the same edge.
    assign wr_fire  = is_ready && RF_en && (RF_wa != '0) && !RF_clr;
    assign rsv_fire = is_ready && RF_rsv_en && (RF_rsv_adr != '0) && !RF_clr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        ram_we    = 1'b0;
        ram_wa    = RF_wa;
        ram_wdata = RF_wd;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_wa    = cnt_q;
            ram_wdata = '0;
            cnt_d     = cnt_q + AW'(1);
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = ST_READY;
            end
        end else if (RF_clr) begin
            state_d = ST_CLEAR;
            cnt_d   = AW'(1);
            busy_d  = '0;
        end else begin
            if (wr_fire) begin
                ram_we         = 1'b1;
                busy_d[RF_wa]  = 1'b0;
            end
            // Reservation applied last: it belongs to the younger instruction.
            if (rsv_fire) begin
                busy_d[RF_rsv_adr] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Data array deliberately has no reset; the clear sequencer initialises it.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[ram_wa] <= ram_wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   rd_adr;
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;

        assign rd_adr = RF_adr[k*AW +: AW];

        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (is_ready && (rd_adr != '0)) begin
                rd_data = ram_q[rd_adr];
                rd_busy = busy_q[rd_adr];
`ifdef RF_BYPASS_EN
                if (wr_fire && (RF_wa == rd_adr)) begin
                    rd_data = RF_wd;
                    rd_busy = rsv_fire && (RF_rsv_adr == rd_adr);
                end
`endif
            end
        end

        assign RF_rd[k*XLEN +: XLEN] = rd_data;
        assign RF_busy[k]            = rd_busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: expected reads queued on a scoreboard as stimulus
// is driven, popped and compared when the outputs are sampled.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic [NRD*AW-1:0]   RF_adr;
    logic [NRD*XLEN-1:0] RF_rd;
    logic [NRD-1:0]      RF_busy;
    logic                RF_en;
    logic [AW-1:0]       RF_wa;
    logic [XLEN-1:0]     RF_wd;
    logic                RF_rsv_en;
    logic [AW-1:0]       RF_rsv_adr;
    logic                RF_clr;
    logic                RF_ready;

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RF_adr     (RF_adr),
        .RF_rd      (RF_rd),
        .RF_busy    (RF_busy),
        .RF_en      (RF_en),
        .RF_wa      (RF_wa),
        .RF_wd      (RF_wd),
        .RF_rsv_en  (RF_rsv_en),
        .RF_rsv_adr (RF_rsv_adr),
        .RF_clr     (RF_clr),
        .RF_ready   (RF_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string           tag;
        int              port;
        logic [XLEN-1:0] rd;
        logic            busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   edges;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [XLEN-1:0] rd, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.rd   = rd;
        e.busy = busy;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, "_rd"}, 64'(RF_rd[e.port*XLEN +: XLEN]), 64'(e.rd));
            check_val({e.tag, "_busy"}, 64'(RF_busy[e.port]), 64'(e.busy));
        end
    endtask

    task automatic sample();
        #1;
        drain();
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_adr(input int p, input logic [AW-1:0] a);
        RF_adr[p*AW +: AW] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; RF_adr = '0; RF_en = 1'b0; RF_wa = '0; RF_wd = '0;
        RF_rsv_en = 1'b0; RF_rsv_adr = '0; RF_clr = 1'b0;

        // Reset, then clear with a write held on reg5 throughout.
        repeat (2) cyc();
        check_val("rst_ready", 64'(RF_ready), 64'd0);
        set_adr(0, 5); set_adr(1, 5);
        expect_rd("rst_rd5", 0, '0, 1'b0);
        sample();
        RF_en = 1'b1; RF_wa = 5; RF_wd = 32'hDEAD;
        RST = 1'b0;
        edges = 0;
        while (!RF_ready && edges < 40) begin
            cyc();
            edges++;
            if (edges == 10) begin
                expect_rd("clr_rd5", 0, '0, 1'b0);
                expect_rd("clr_rd5p1", 1, '0, 1'b0);
                sample();
            end
        end
        check_val("rst_ready_edges", 64'(edges), 64'd31);
        expect_rd("rdy_rd5_pre", 0, BYP ? 32'hDEAD : 32'h0, 1'b0);
        sample();
        cyc();
        RF_en = 1'b0;
        expect_rd("rdy_rd5_post", 0, 32'hDEAD, 1'b0);
        sample();

        // Basic write/read on both ports, x0 write dropped.
        RF_en = 1'b1; RF_wa = 7; RF_wd = 32'h12345678;
        cyc();
        RF_en = 1'b0;
        set_adr(0, 7); set_adr(1, 7);
        expect_rd("wr7_p0", 0, 32'h12345678, 1'b0);
        expect_rd("wr7_p1", 1, 32'h12345678, 1'b0);
        sample();
        RF_en = 1'b1; RF_wa = 0; RF_wd = 32'hFFFFFFFF;
        set_adr(0, 0);
        cyc();
        RF_en = 1'b0;
        expect_rd("x0_rd", 0, '0, 1'b0);
        expect_rd("x0_p1_r7", 1, 32'h12345678, 1'b0);
        sample();

        // Scoreboard on reg9.
        RF_rsv_en = 1'b1; RF_rsv_adr = 9; set_adr(0, 9);
        expect_rd("rsv9_pre", 0, '0, 1'b0);
        sample();
        cyc();
        RF_rsv_en = 1'b0;
        expect_rd("rsv9_post", 0, '0, 1'b1);
        sample();
        RF_en = 1'b1; RF_wa = 9; RF_wd = 32'hA5;
        expect_rd("wr9_pre", 0, BYP ? 32'hA5 : 32'h0, BYP ? 1'b0 : 1'b1);
        sample();
        cyc();
        RF_en = 1'b0;
        expect_rd("wr9_post", 0, 32'hA5, 1'b0);
        sample();
        RF_en = 1'b1; RF_wa = 9; RF_wd = 32'h5A; RF_rsv_en = 1'b1; RF_rsv_adr = 9;
        expect_rd("wrrsv9_pre", 0, BYP ? 32'h5A : 32'hA5, BYP ? 1'b1 : 1'b0);
        sample();
        cyc();
        RF_en = 1'b0; RF_rsv_en = 1'b0;
        expect_rd("wrrsv9_post", 0, 32'h5A, 1'b1);
        sample();

        // Bypass / write latency on reg3, port1 independent on reg7.
        RF_en = 1'b1; RF_wa = 3; RF_wd = 32'h11;
        cyc();
        RF_wd = 32'h55;
        set_adr(0, 3); set_adr(1, 7);
        expect_rd("byp3_pre", 0, BYP ? 32'h55 : 32'h11, 1'b0);
        expect_rd("byp3_p1", 1, 32'h12345678, 1'b0);
        sample();
        cyc();
        RF_en = 1'b0;
        expect_rd("byp3_post", 0, 32'h55, 1'b0);
        sample();

        // Soft clear: load all, reserve reg4, clear with dropped write/reservation.
        for (int i = 1; i < NREG; i++) begin
            RF_en = 1'b1; RF_wa = AW'(i); RF_wd = 32'hA5000000 | 32'(i);
            cyc();
        end
        RF_en = 1'b0;
        RF_rsv_en = 1'b1; RF_rsv_adr = 4;
        cyc();
        RF_rsv_en = 1'b0;
        set_adr(0, 31); set_adr(1, 4);
        expect_rd("load_r31", 0, 32'hA500001F, 1'b0);
        expect_rd("load_r4", 1, 32'hA5000004, 1'b1);
        sample();
        RF_clr = 1'b1;
        RF_en = 1'b1; RF_wa = 2; RF_wd = 32'h77;
        RF_rsv_en = 1'b1; RF_rsv_adr = 6;
        cyc();
        RF_clr = 1'b0;
        check_val("sclr_ready_drop", 64'(RF_ready), 64'd0);
        set_adr(0, 2); set_adr(1, 4);
        edges = 0;
        while (!RF_ready && edges < 40) begin
            RF_clr = (edges == 4);
            cyc();
            edges++;
            if (edges < 31) begin
                expect_rd("sclr_r2", 0, '0, 1'b0);
                expect_rd("sclr_r4", 1, '0, 1'b0);
                sample();
            end
        end
        RF_clr = 1'b0; RF_en = 1'b0; RF_rsv_en = 1'b0;
        check_val("sclr_edges", 64'(edges + 1), 64'd32);
        set_adr(1, 6);
        for (int j = 1; j < NREG; j++) begin
            set_adr(0, AW'(j));
            expect_rd($sformatf("sclr_after_r%0d", j), 0, '0, 1'b0);
            sample();
        end
        expect_rd("sclr_after_busy6", 1, '0, 1'b0);
        sample();

        // Reset in the middle of a soft clear.
        RF_clr = 1'b1;
        cyc();
        RF_clr = 1'b0;
        repeat (9) cyc();
        check_val("midclr_ready", 64'(RF_ready), 64'd0);
        RST = 1'b1;
        #1;
        check_val("midclr_rst_ready", 64'(RF_ready), 64'd0);
        cyc();
        RST = 1'b0;
        edges = 0;
        while (!RF_ready && edges < 40) begin
            cyc();
            edges++;
        end
        check_val("midclr_edges", 64'(edges), 64'd31);

        // Top register and busy seen on both ports.
        RF_en = 1'b1; RF_wa = 31; RF_wd = 32'hCAFEF00D;
        RF_rsv_en = 1'b1; RF_rsv_adr = 31;
        cyc();
        RF_en = 1'b0; RF_rsv_en = 1'b0;
        set_adr(0, 31); set_adr(1, 31);
        expect_rd("top_p0", 0, 32'hCAFEF00D, 1'b1);
        expect_rd("top_p1", 1, 32'hCAFEF00D, 1'b1);
        sample();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
